pw_arm_ctrl: RTL and testbench

Arm/sequence controller for the trigger and capture path, in the fe_clk domain. Converts a single software arm into N capture segments. Per segment it enables the trigger block, waits for a pattern match, then waits for the resulting capture to finish. It also handles an optional inter-segment gap, a per-segment match timeout, and disarm/abort, and reports status back to the register block.

---
 rtl/pw_pkg.sv | 20 ++
 rtl/pw_arm_ctrl_if.sv | 58 +++++
 rtl/pw_loadable_counter.sv | 36 +++
 rtl/pw_arm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pw_arm_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pw_pkg.sv
// Shared definitions for the arm/sequence controller: state encoding and default widths.
package pw_pkg;

  localparam int unsigned pDEF_SEGMENT_WIDTH = 8;
  localparam int unsigned pDEF_TIMEOUT_WIDTH = 24;
  localparam int unsigned pDEF_GAP_WIDTH     = 16;

  localparam int unsigned pS_IDLE    = 0;
  localparam int unsigned pS_ARMED   = 1;
  localparam int unsigned pS_CAPTURE = 2;
  localparam int unsigned pS_GAP     = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'(pS_IDLE),
    StArmed   = 2'(pS_ARMED),
    StCapture = 2'(pS_CAPTURE),
    StGap     = 2'(pS_GAP)
  } pw_state_e;

endpackage

// File: rtl/pw_arm_ctrl_if.sv
// Register-block / trigger-path signal bundle for pw_arm_ctrl.
interface pw_arm_ctrl_if #(
  parameter int unsigned pSEGMENT_WIDTH = pw_pkg::pDEF_SEGMENT_WIDTH,
  parameter int unsigned pTIMEOUT_WIDTH = pw_pkg::pDEF_TIMEOUT_WIDTH,
  parameter int unsigned pGAP_WIDTH     = pw_pkg::pDEF_GAP_WIDTH
);

  logic                      I_arm;
  logic                      I_disarm;
  logic [pSEGMENT_WIDTH-1:0] I_num_segments;
  logic [pTIMEOUT_WIDTH-1:0] I_timeout;
  logic [pGAP_WIDTH-1:0]     I_rearm_gap;
  logic                      I_match;
  logic                      I_capturing;

  logic                      O_trigger_enable;
  logic                      O_pattern_reset;
  logic                      O_armed;
  logic                      O_busy;
  logic [pSEGMENT_WIDTH-1:0] O_segment_count;
  logic                      O_timeout;
  logic                      O_done;

  modport master (
    output I_arm,
    output I_disarm,
    output I_num_segments,
    output I_timeout,
    output I_rearm_gap,
    output I_match,
    output I_capturing,
    input  O_trigger_enable,
    input  O_pattern_reset,
    input  O_armed,
    input  O_busy,
    input  O_segment_count,
    input  O_timeout,
    input  O_done
  );

  modport slave (
    input  I_arm,
    input  I_disarm,
    input  I_num_segments,
    input  I_timeout,
    input  I_rearm_gap,
    input  I_match,
    input  I_capturing,
    output O_trigger_enable,
    output O_pattern_reset,
    output O_armed,
    output O_busy,
    output O_segment_count,
    output O_timeout,
    output O_done
  );

endinterface

// File: rtl/pw_loadable_counter.sv
// Up-counter with synchronous clear, enable, saturation at all-ones and a terminal flag
// raised while the count equals the supplied limit.
module pw_loadable_counter #(
  parameter int unsigned pWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [pWIDTH-1:0] limit,
  output logic              term
);

  logic [pWIDTH-1:0] count_q;
  logic [pWIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {pWIDTH{1'b1}})) begin
      count_d = count_q + pWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term = (count_q == limit);

endmodule

// File: rtl/pw_arm_ctrl.sv
// Arm/sequence controller: turns one software arm into N match+capture segments with
// optional inter-segment gap, per-segment match timeout and disarm.
module pw_arm_ctrl
  import pw_pkg::*;
#(
  parameter int unsigned pSEGMENT_WIDTH = pDEF_SEGMENT_WIDTH,
  parameter int unsigned pTIMEOUT_WIDTH = pDEF_TIMEOUT_WIDTH,
  parameter int unsigned pGAP_WIDTH     = pDEF_GAP_WIDTH
) (
  input logic         fe_clk,
  input logic         reset_n,
  pw_arm_ctrl_if.slave bus
);

  pw_state_e state_q, state_d;

  logic [pSEGMENT_WIDTH-1:0] nseg_q, nseg_d;
  logic [pTIMEOUT_WIDTH-1:0] tmo_cfg_q, tmo_cfg_d;
  logic [pGAP_WIDTH-1:0]     gap_cfg_q, gap_cfg_d;
  logic [pSEGMENT_WIDTH-1:0] seg_q, seg_d;
  logic [pSEGMENT_WIDTH-1:0] seg_inc;

  logic te_q, te_d;
  logic pr_q, pr_d;
  logic tmo_q, tmo_d;
  logic done_q, done_d;
  logic seen_q, seen_d;
  logic capr_q;

  logic timer_term;
  logic gap_term;
  logic capture_end;

  // Match timer: held at zero outside ARMED so every ARMED entry starts from 0.
  pw_loadable_counter #(
    .pWIDTH (pTIMEOUT_WIDTH)
  ) u_match_timer (
    .clk   (fe_clk),
    .rst_n (reset_n),
    .clr   (state_q != StArmed),
    .en    (state_q == StArmed),
    .limit (tmo_cfg_q - pTIMEOUT_WIDTH'(1)),
    .term  (timer_term)
  );

  pw_loadable_counter #(
    .pWIDTH (pGAP_WIDTH)
  ) u_gap_counter (
    .clk   (fe_clk),
    .rst_n (reset_n),
    .clr   (state_q != StGap),
    .en    (state_q == StGap),
    .limit (gap_cfg_q - pGAP_WIDTH'(1)),
    .term  (gap_term)
  );

  assign capture_end = seen_q & capr_q & ~bus.I_capturing;
  assign seg_inc     = seg_q + pSEGMENT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    nseg_d    = nseg_q;
    tmo_cfg_d = tmo_cfg_q;
    gap_cfg_d = gap_cfg_q;
    seg_d     = seg_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    pr_d      = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.I_arm && !bus.I_disarm) begin
          nseg_d    = (bus.I_num_segments == '0) ? pSEGMENT_WIDTH'(1) : bus.I_num_segments;
          tmo_cfg_d = bus.I_timeout;
          gap_cfg_d = bus.I_rearm_gap;
          seg_d     = '0;
          tmo_d     = 1'b0;
          pr_d      = 1'b1;
          state_d   = StArmed;
        end
      end

      StArmed: begin
        if (bus.I_disarm) begin
          state_d = StIdle;
        end else if (bus.I_match) begin
          // A capture that is already busy in the match cycle still counts.
          seen_d  = bus.I_capturing;
          state_d = StCapture;
        end else if ((tmo_cfg_q != '0) && timer_term) begin
          tmo_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      StCapture: begin
        if (bus.I_disarm) begin
          state_d = StIdle;
        end else begin
          if (bus.I_capturing) begin
            seen_d = 1'b1;
          end
          if (capture_end) begin
            seg_d = seg_inc;
            if (seg_inc == nseg_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else if (gap_cfg_q != '0) begin
              state_d = StGap;
            end else begin
              pr_d    = 1'b1;
              state_d = StArmed;
            end
          end
        end
      end

      StGap: begin
        if (bus.I_disarm) begin
          state_d = StIdle;
        end else if (gap_term) begin
          pr_d    = 1'b1;
          state_d = StArmed;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    te_d = (state_d == StArmed) || (state_d == StCapture);
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      nseg_q    <= '0;
      tmo_cfg_q <= '0;
      gap_cfg_q <= '0;
      seg_q     <= '0;
      te_q      <= 1'b0;
      pr_q      <= 1'b0;
      tmo_q     <= 1'b0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
      capr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nseg_q    <= nseg_d;
      tmo_cfg_q <= tmo_cfg_d;
      gap_cfg_q <= gap_cfg_d;
      seg_q     <= seg_d;
      te_q      <= te_d;
      pr_q      <= pr_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      seen_q    <= seen_d;
      capr_q    <= bus.I_capturing;
    end
  end

  assign bus.O_trigger_enable = te_q;
  assign bus.O_pattern_reset  = pr_q;
  assign bus.O_segment_count  = seg_q;
  assign bus.O_timeout        = tmo_q;
  assign bus.O_done           = done_q;
  assign bus.O_armed          = (state_q == StArmed);
  assign bus.O_busy           = (state_q != StIdle);

endmodule

// File: tb/tb_pw_arm_ctrl.sv
// Directed bench for pw_arm_ctrl; O_done events are checked against a queue of expectations.
module tb_pw_arm_ctrl;

  localparam int unsigned SW = 8;
  localparam int unsigned TW = 24;
  localparam int unsigned GW = 16;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   pr_cnt  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    int          at;
    logic [SW-1:0] seg;
    logic        tmo;
  } exp_t;

  exp_t sb[$];

  pw_arm_ctrl_if #(.pSEGMENT_WIDTH(SW), .pTIMEOUT_WIDTH(TW), .pGAP_WIDTH(GW)) bus ();

  pw_arm_ctrl #(
    .pSEGMENT_WIDTH (SW),
    .pTIMEOUT_WIDTH (TW),
    .pGAP_WIDTH     (GW)
  ) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 fe_clk = ~fe_clk;

  always @(posedge fe_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: each O_done pulse must match the oldest queued expectation.
  always @(negedge fe_clk) begin
    exp_t e;
    if (bus.O_pattern_reset === 1'b1) pr_cnt++;
    if (bus.O_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("done_seg_count", bus.O_segment_count, e.seg);
        chk("done_timeout", bus.O_timeout, e.tmo);
        chk("done_busy", bus.O_busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge fe_clk);
  endtask

  task automatic expect_done(input int at, input int seg, input bit tmo);
    exp_t e;
    e.at  = at;
    e.seg = SW'(seg);
    e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic cfg(input int nseg, input int tmo, input int gap);
    bus.I_num_segments = SW'(nseg);
    bus.I_timeout      = TW'(tmo);
    bus.I_rearm_gap    = GW'(gap);
  endtask

  task automatic pulse_arm();
    bus.I_arm = 1'b1;
    step();
    bus.I_arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    bus.I_disarm = 1'b1;
    step();
    bus.I_disarm = 1'b0;
  endtask

  task automatic wait_te(input string name);
    int n = 0;
    while (bus.O_trigger_enable !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(name, bus.O_trigger_enable, 1);
  endtask

  // Match pulse, then capturing high for len cycles; returns the cycle it was dropped.
  task automatic capture(input int len, output int drop_cyc);
    bus.I_match = 1'b1;
    step();
    bus.I_match     = 1'b0;
    bus.I_capturing = 1'b1;
    step(len);
    bus.I_capturing = 1'b0;
    drop_cyc = cyc;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_te"}, bus.O_trigger_enable, 0);
    chk({pfx, "_pr"}, bus.O_pattern_reset, 0);
    chk({pfx, "_armed"}, bus.O_armed, 0);
    chk({pfx, "_busy"}, bus.O_busy, 0);
    chk({pfx, "_seg"}, bus.O_segment_count, 0);
    chk({pfx, "_tmo"}, bus.O_timeout, 0);
    chk({pfx, "_done"}, bus.O_done, 0);
  endtask

  initial begin
    int d;
    int c;
    int n;
    int pr_base;

    bus.I_arm = 1'b0;
    bus.I_disarm = 1'b0;
    bus.I_match = 1'b0;
    bus.I_capturing = 1'b0;
    cfg(1, 0, 0);

    step(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Single segment, no timeout
    chk("t1_te_before_arm", bus.O_trigger_enable, 0);
    pulse_arm();
    chk("t1_te_latency", bus.O_trigger_enable, 1);
    chk("t1_armed", bus.O_armed, 1);
    chk("t1_busy", bus.O_busy, 1);
    chk("t1_pattern_reset", bus.O_pattern_reset, 1);
    step(49);
    capture(20, d);
    expect_done(d + 1, 1, 0);
    step(3);
    chk("t1_seg_after", bus.O_segment_count, 1);
    chk("t1_busy_after", bus.O_busy, 0);
    chk("t1_te_after", bus.O_trigger_enable, 0);

    // Three segments with a 10-cycle gap
    cfg(3, 0, 10);
    pr_base = pr_cnt;
    pulse_arm();
    for (int s = 1; s <= 3; s++) begin
      wait_te("t2_te_rise");
      step(5);
      capture(4, d);
      if (s < 3) begin
        step();
        n = 0;
        while (bus.O_trigger_enable === 1'b0 && n < 50) begin
          n++;
          step();
        end
        chk("t2_gap_len", n, 10);
      end else begin
        expect_done(d + 1, 3, 0);
      end
    end
    step(3);
    chk("t2_pattern_resets", pr_cnt - pr_base, 3);
    chk("t2_seg", bus.O_segment_count, 3);

    // Timeout with no match, then a match in the expiry cycle
    cfg(1, 100, 0);
    c = cyc;
    pulse_arm();
    expect_done(c + 101, 0, 1);
    step(110);
    chk("t3_tmo_sticky", bus.O_timeout, 1);
    chk("t3_seg", bus.O_segment_count, 0);
    chk("t3_busy", bus.O_busy, 0);
    c = cyc;
    pulse_arm();
    chk("t3_tmo_cleared", bus.O_timeout, 0);
    step(99);
    bus.I_match = 1'b1;
    step();
    bus.I_match = 1'b0;
    chk("t3_race_busy", bus.O_busy, 1);
    chk("t3_race_armed", bus.O_armed, 0);
    chk("t3_race_tmo", bus.O_timeout, 0);
    bus.I_capturing = 1'b1;
    step(3);
    bus.I_capturing = 1'b0;
    expect_done(cyc + 1, 1, 0);
    step(3);
    chk("t3_race_tmo_end", bus.O_timeout, 0);

    // Disarm mid-capture on segment 2 of 4
    cfg(4, 0, 0);
    pulse_arm();
    wait_te("t4_te1");
    step(3);
    capture(4, d);
    step();
    wait_te("t4_te2");
    step(2);
    bus.I_match = 1'b1;
    step();
    bus.I_match = 1'b0;
    bus.I_capturing = 1'b1;
    step(2);
    pulse_disarm();
    chk("t4_busy", bus.O_busy, 0);
    chk("t4_te", bus.O_trigger_enable, 0);
    chk("t4_seg", bus.O_segment_count, 1);
    bus.I_capturing = 1'b0;
    step(3);
    chk("t4_seg_held", bus.O_segment_count, 1);
    pulse_arm();
    chk("t4_rearm_seg", bus.O_segment_count, 0);
    pulse_disarm();
    chk("t4_cleanup_busy", bus.O_busy, 0);

    // num_segments=0 acts as 1; capturing high only in the match cycle
    cfg(0, 0, 0);
    pulse_arm();
    step(3);
    bus.I_match = 1'b1;
    bus.I_capturing = 1'b1;
    c = cyc;
    step();
    bus.I_match = 1'b0;
    bus.I_capturing = 1'b0;
    expect_done(c + 2, 1, 0);
    step(3);
    chk("t5_seg", bus.O_segment_count, 1);
    chk("t5_busy", bus.O_busy, 0);

    // Arm and disarm together
    bus.I_arm = 1'b1;
    bus.I_disarm = 1'b1;
    step();
    bus.I_arm = 1'b0;
    bus.I_disarm = 1'b0;
    chk("t6_busy", bus.O_busy, 0);
    chk("t6_te", bus.O_trigger_enable, 0);
    chk("t6_pr", bus.O_pattern_reset, 0);

    // Arm while busy is ignored
    cfg(2, 0, 0);
    pulse_arm();
    step(2);
    capture(3, d);
    step();
    chk("t7_armed", bus.O_armed, 1);
    chk("t7_seg", bus.O_segment_count, 1);
    pulse_arm();
    chk("t7_pr", bus.O_pattern_reset, 0);
    chk("t7_seg_kept", bus.O_segment_count, 1);
    chk("t7_still_armed", bus.O_armed, 1);
    pulse_disarm();

    // Asynchronous reset in the middle of a gap
    cfg(2, 0, 10);
    pulse_arm();
    step(2);
    capture(3, d);
    step(4);
    chk("t8_in_gap_te", bus.O_trigger_enable, 0);
    chk("t8_in_gap_seg", bus.O_segment_count, 1);
    chk("t8_in_gap_busy", bus.O_busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("t8_async");
    step();
    reset_n = 1'b1;
    step();
    chk("t8_idle_after", bus.O_busy, 0);
    cfg(1, 0, 0);
    pulse_arm();
    chk("t8_rearm_busy", bus.O_busy, 1);
    step(2);
    capture(2, d);
    expect_done(d + 1, 1, 0);
    step(5);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
